// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/enable generator with per-channel shadow settings
// that are applied only at period boundaries, plus a global phase-align input.
module clk_div_multi #(
    parameter int unsigned CH      = 4,
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [CH-1:0]    en,
    input  logic             sync,
    input  logic             load,
    input  logic [3:0]       load_ch,
    input  logic [WIDTH-1:0] load_div,
    input  logic [WIDTH-1:0] load_high,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    pending
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DefCnt = WIDTH'(DEF_DIV - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);
    localparam logic [WIDTH-1:0] Two    = WIDTH'(2);

    function automatic logic [WIDTH-1:0] div_eff(input logic [WIDTH-1:0] div);
        return (div < Two) ? Two : div;
    endfunction

    // High time 0 selects 50% (rounded down); otherwise clamp so the low phase is never empty.
    function automatic logic [WIDTH-1:0] high_eff(input logic [WIDTH-1:0] div,
                                                  input logic [WIDTH-1:0] high);
        logic [WIDTH-1:0] de;
        de = div_eff(div);
        if (high == '0) begin
            return de >> 1;
        end
        if (high > de - One) begin
            return de - One;
        end
        return high;
    endfunction

    logic load_hit;
    assign load_hit = load && (32'(load_ch) < CH);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] div_q, div_d, high_q, high_d;
        logic [WIDTH-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] de_cur, de_new, he_new;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             sel, wrap, apply;

        assign sel = load_hit && (load_ch == 4'(i));

        always_comb begin
            de_cur = div_eff(div_q);
            wrap   = sync || (cnt_q == de_cur - One);
            // A disabled channel has no period to protect, so shadow applies at once.
            apply  = pend_q && (wrap || !en[i]);

            div_d  = apply ? sdiv_q  : div_q;
            high_d = apply ? shigh_q : high_q;
            de_new = div_eff(div_d);
            he_new = high_eff(div_d, high_d);

            // A same-edge load lands after the old shadow has been consumed.
            sdiv_d  = sel ? load_div  : sdiv_q;
            shigh_d = sel ? load_high : shigh_q;
            pend_d  = sel ? 1'b1 : (apply ? 1'b0 : pend_q);

            if (en[i]) begin
                cnt_d  = wrap ? '0 : cnt_q + One;
                clk_d  = (cnt_d < he_new);
                tick_d = wrap;
            end else begin
                cnt_d  = de_new - One;
                clk_d  = 1'b0;
                tick_d = 1'b0;
            end
        end

        always_ff @(posedge clk_in) begin
            if (reset) begin
                div_q   <= DefDiv;
                high_q  <= '0;
                sdiv_q  <= DefDiv;
                shigh_q <= '0;
                pend_q  <= 1'b0;
                cnt_q   <= DefCnt;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_q   <= div_d;
                high_q  <= high_d;
                sdiv_q  <= sdiv_d;
                shigh_q <= shigh_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with two channels: reset, restart, loads, clamps,
// sync alignment and reset/ignored-load behaviour.
module tb_clk_div_multi;

    localparam int unsigned CH    = 2;
    localparam int unsigned WIDTH = 11;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [CH-1:0]    en;
    logic             sync;
    logic             load;
    logic [3:0]       load_ch;
    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] load_high;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    pending;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(
        .CH      (CH),
        .WIDTH   (WIDTH),
        .DEF_DIV (4)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .load      (load),
        .load_ch   (load_ch),
        .load_div  (load_div),
        .load_high (load_high),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_load(input logic [3:0] ch, input int unsigned d, input int unsigned h);
        load      = 1'b1;
        load_ch   = ch;
        load_div  = WIDTH'(d);
        load_high = WIDTH'(h);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 2'b00;
        sync      = 1'b0;
        load      = 1'b0;
        load_ch   = 4'd0;
        load_div  = '0;
        load_high = '0;
        step();
        step();
        check("rst_clk", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_pend", 32'(pending), 32'h0);
        reset = 1'b0;

        // Default divide-by-4 on channel 0 from the parked state
        en = 2'b01;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_clk", 32'(clk_out), 32'({1'b0, (k % 4) < 2}));
            check("t1_tick", 32'(tick), 32'({1'b0, (k % 4) == 0}));
            check("t1_pend", 32'(pending), 32'h0);
        end

        // Load a disabled channel: shadow applies on the very next edge
        en = 2'b00;
        set_load(4'd1, 5, 1);
        step();
        check("t2_pend_set", 32'(pending), 32'h2);
        check("t2_clk_off", 32'(clk_out), 32'h0);
        load = 1'b0;
        step();
        check("t2_pend_clr", 32'(pending), 32'h0);
        en = 2'b10;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t2_clk", 32'(clk_out), 32'({(k % 5) == 0, 1'b0}));
            check("t2_tick", 32'(tick), 32'({(k % 5) == 0, 1'b0}));
        end

        // Rate change mid-period on a running channel waits for the natural wrap
        en = 2'b01;
        step();
        check("t3_start_clk", 32'(clk_out), 32'h1);
        check("t3_start_tick", 32'(tick), 32'h1);
        step();
        check("t3_cnt1_clk", 32'(clk_out), 32'h1);
        set_load(4'd0, 6, 0);
        step();
        check("t3_ld_pend", 32'(pending), 32'h1);
        check("t3_ld_clk", 32'(clk_out), 32'h0);
        check("t3_ld_tick", 32'(tick), 32'h0);
        load = 1'b0;
        step();
        check("t3_old_pend", 32'(pending), 32'h1);
        check("t3_old_clk", 32'(clk_out), 32'h0);
        for (int k = 0; k < 12; k++) begin
            step();
            check("t3_clk", 32'(clk_out), 32'({1'b0, (k % 6) < 3}));
            check("t3_tick", 32'(tick), 32'({1'b0, (k % 6) == 0}));
            check("t3_pend", 32'(pending), 32'h0);
        end

        // Clamp: div=1 behaves as 2
        en = 2'b00;
        set_load(4'd0, 1, 0);
        step();
        check("t4a_pend", 32'(pending), 32'h1);
        load = 1'b0;
        step();
        check("t4a_pend_clr", 32'(pending), 32'h0);
        en = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t4a_clk", 32'(clk_out), 32'({1'b0, (k % 2) == 0}));
            check("t4a_tick", 32'(tick), 32'({1'b0, (k % 2) == 0}));
        end

        // Clamp: high=9 with div=5 gives 4 high / 1 low
        en = 2'b00;
        set_load(4'd0, 5, 9);
        step();
        load = 1'b0;
        step();
        check("t4b_pend_clr", 32'(pending), 32'h0);
        en = 2'b01;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4b_clk", 32'(clk_out), 32'({1'b0, (k % 5) < 4}));
            check("t4b_tick", 32'(tick), 32'({1'b0, (k % 5) == 0}));
        end

        // Sync: ch0 div 4 at its natural wrap, ch1 div 6 mid-period
        en = 2'b00;
        set_load(4'd0, 4, 0);
        step();
        set_load(4'd1, 6, 0);
        step();
        load = 1'b0;
        step();
        check("t5_pend", 32'(pending), 32'h0);
        en = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_pre_clk", 32'(clk_out), 32'({(k % 6) < 3, (k % 4) < 2}));
            check("t5_pre_tick", 32'(tick), 32'({(k % 6) == 0, (k % 4) == 0}));
        end
        sync = 1'b1;
        step();
        check("t5_sync_clk", 32'(clk_out), 32'h3);
        check("t5_sync_tick", 32'(tick), 32'h3);
        sync = 1'b0;
        for (int k = 1; k < 13; k++) begin
            step();
            check("t5_post_clk", 32'(clk_out), 32'({(k % 6) < 3, (k % 4) < 2}));
            check("t5_post_tick", 32'(tick), 32'({(k % 6) == 0, (k % 4) == 0}));
        end

        // Reset with a pending shadow, then an out-of-range load
        set_load(4'd1, 3, 0);
        step();
        check("t6_pend_set", 32'(pending), 32'h2);
        load  = 1'b0;
        en    = 2'b00;
        reset = 1'b1;
        step();
        check("t6_rst_clk", 32'(clk_out), 32'h0);
        check("t6_rst_tick", 32'(tick), 32'h0);
        check("t6_rst_pend", 32'(pending), 32'h0);
        reset = 1'b0;
        set_load(4'd2, 7, 1);
        step();
        check("t6_bad_ch_pend", 32'(pending), 32'h0);
        check("t6_bad_ch_clk", 32'(clk_out), 32'h0);
        load = 1'b0;
        en   = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t6_clk", 32'(clk_out), 32'({(k % 4) < 2, (k % 4) < 2}));
            check("t6_tick", 32'(tick), 32'({(k % 4) == 0, (k % 4) == 0}));
            check("t6_pend", 32'(pending), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
